// File: rtl/conv_seq_pkg.sv
// Shared types and default widths for the convolution control sequencer.
package conv_seq_pkg;

  localparam int SIG_AW_DEF   = 10;
  localparam int W_AW_DEF     = 8;
  localparam int N_W_DEF      = 16;
  localparam int PIPE_LAT_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } conv_seq_state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Tap counter, window base accumulator and output counter for one layer run.
module conv_addr_gen
  import conv_seq_pkg::*;
#(
  parameter int SIG_AW = SIG_AW_DEF,
  parameter int W_AW   = W_AW_DEF,
  parameter int N_W    = N_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [W_AW-1:0]   cfg_k,
  input  logic [N_W-1:0]    cfg_n,
  input  logic [SIG_AW-1:0] cfg_base,
  input  logic [SIG_AW-1:0] cfg_stride,
  input  logic              tap_adv,
  input  logic              win_adv,
  output logic [SIG_AW-1:0] tap_addr,
  output logic [W_AW-1:0]   tap,
  output logic [N_W-1:0]    win_idx,
  output logic              first_tap,
  output logic              last_tap,
  output logic              last_win
);

  logic [W_AW-1:0]   k_q;
  logic [N_W-1:0]    n_q;
  logic [SIG_AW-1:0] stride_q;
  logic [SIG_AW-1:0] base_q;
  logic [W_AW-1:0]   tap_q;
  logic [N_W-1:0]    win_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q      <= '0;
      n_q      <= '0;
      stride_q <= '0;
      base_q   <= '0;
      tap_q    <= '0;
      win_q    <= '0;
    end else if (load) begin
      k_q      <= cfg_k;
      n_q      <= cfg_n;
      stride_q <= cfg_stride;
      base_q   <= cfg_base;
      tap_q    <= '0;
      win_q    <= '0;
    end else begin
      if (tap_adv) tap_q <= last_tap ? '0 : tap_q + 1'b1;
      if (win_adv) begin
        base_q <= base_q + stride_q;
        win_q  <= win_q + 1'b1;
      end
    end
  end

  // Address arithmetic wraps naturally at 2^SIG_AW.
  assign tap_addr  = base_q + SIG_AW'(tap_q);
  assign tap       = tap_q;
  assign win_idx   = win_q;
  assign first_tap = (tap_q == '0);
  assign last_tap  = (tap_q == k_q - 1'b1);
  assign last_win  = (win_q == n_q - 1'b1);

endmodule

// File: rtl/conv_sequencer.sv
// Sequencer for the convolve MAC/saturation datapath: fetches taps, drives MAC
// strobes, captures each saturated result and offers it on a valid/ready port.
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int SIG_AW   = SIG_AW_DEF,
  parameter int W_AW     = W_AW_DEF,
  parameter int N_W      = N_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [W_AW-1:0]     cfg_k,
  input  logic [N_W-1:0]      cfg_n,
  input  logic [SIG_AW-1:0]   cfg_base,
  input  logic [SIG_AW-1:0]   cfg_stride,
  output logic                busy,
  output logic                done,
  output logic [SIG_AW-1:0]   sig_addr,
  output logic [W_AW-1:0]     w_addr,
  output logic                mem_rd,
  output logic                mac_clken,
  output logic                mac_sload,
  output logic                mac_en_mult_r,
  output logic                mac_en_sat,
  input  logic signed [7:0]   convout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [7:0]   out_data,
  output logic [N_W-1:0]      out_idx
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  conv_seq_state_t   state_q, state_d;
  logic [DW-1:0]     drain_q;
  logic              in_issue, drain_last, handshake, load;
  logic [SIG_AW-1:0] tap_addr;
  logic [W_AW-1:0]   tap;
  logic [N_W-1:0]    win_idx;
  logic              first_tap, last_tap, last_win;

  assign in_issue   = (state_q == ST_ISSUE);
  assign drain_last = (state_q == ST_DRAIN) && (drain_q == DW'(PIPE_LAT - 1));
  assign handshake  = (state_q == ST_EMIT) && out_ready;
  assign load       = (state_q == ST_IDLE) && start;

  conv_addr_gen #(.SIG_AW(SIG_AW), .W_AW(W_AW), .N_W(N_W)) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .cfg_k      (cfg_k),
    .cfg_n      (cfg_n),
    .cfg_base   (cfg_base),
    .cfg_stride (cfg_stride),
    .tap_adv    (in_issue),
    .win_adv    (handshake),
    .tap_addr   (tap_addr),
    .tap        (tap),
    .win_idx    (win_idx),
    .first_tap  (first_tap),
    .last_tap   (last_tap),
    .last_win   (last_win)
  );

  // NOTE: next state defaults to the current state first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_k == '0 || cfg_n == '0) state_d = ST_DONE;
          else                            state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: if (last_tap)   state_d = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_d = ST_EMIT;
      ST_EMIT: begin
        if (out_ready) begin
          if (last_win) state_d = ST_DONE;
          else          state_d = ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The strobe stage lines MAC enables up with memory data returning one cycle after the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      drain_q   <= '0;
      mac_clken <= 1'b0;
      mac_sload <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= ((state_q == ST_DRAIN) && !drain_last) ? drain_q + 1'b1 : '0;
      mac_clken <= in_issue;
      mac_sload <= in_issue && first_tap;
      if (drain_last) begin
        out_data <= convout;
        out_idx  <= win_idx;
      end
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign mem_rd        = in_issue;
  assign sig_addr      = in_issue ? tap_addr : '0;
  assign w_addr        = in_issue ? tap : '0;
  assign mac_en_mult_r = busy;
  assign mac_en_sat    = busy;
  assign out_valid     = (state_q == ST_EMIT);

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed self-checking bench for conv_sequencer with hand-computed expectations.
module tb_conv_sequencer;

  logic               clk;
  logic               reset;
  logic               start;
  logic [7:0]         cfg_k;
  logic [15:0]        cfg_n;
  logic [9:0]         cfg_base;
  logic [9:0]         cfg_stride;
  logic               busy, done, mem_rd;
  logic [9:0]         sig_addr;
  logic [7:0]         w_addr;
  logic               mac_clken, mac_sload, mac_en_mult_r, mac_en_sat;
  logic signed [7:0]  convout;
  logic               out_valid, out_ready;
  logic signed [7:0]  out_data;
  logic [15:0]        out_idx;

  int tests = 0;
  int fails = 0;

  logic       exp_issue, exp_clken, exp_sload, exp_valid, exp_done, exp_busy;
  logic       seen_any;
  logic       got_done;
  int         ai;
  logic [9:0] exp_sa2 [6] = '{10'd0, 10'd1, 10'd2, 10'd1, 10'd2, 10'd3};
  logic [7:0] exp_wa2 [6] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
  logic [9:0] exp_sa5 [8] = '{10'd1020, 10'd1021, 10'd1022, 10'd1023,
                              10'd1023, 10'd0, 10'd1, 10'd2};
  logic [9:0] addr_q [$];

  conv_sequencer #(.SIG_AW(10), .W_AW(8), .N_W(16), .PIPE_LAT(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_k         (cfg_k),
    .cfg_n         (cfg_n),
    .cfg_base      (cfg_base),
    .cfg_stride    (cfg_stride),
    .busy          (busy),
    .done          (done),
    .sig_addr      (sig_addr),
    .w_addr        (w_addr),
    .mem_rd        (mem_rd),
    .mac_clken     (mac_clken),
    .mac_sload     (mac_sload),
    .mac_en_mult_r (mac_en_mult_r),
    .mac_en_sat    (mac_en_sat),
    .convout       (convout),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_idx       (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {14'd0, busy, done, mem_rd, sig_addr, w_addr, mac_clken, mac_sload,
            mac_en_mult_r, mac_en_sat, out_valid, out_data, out_idx};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; cfg_k = '0; cfg_n = '0; cfg_base = '0;
    cfg_stride = '0; convout = '0; out_ready = 1'b0;
    step(); step();
    check("reset_all_outputs", all_outs(), 64'd0);
    reset = 1'b0;
    step();
    check("idle_all_outputs", all_outs(), 64'd0);

    // K=3, N=2, base 0, stride 1, ready tied high; a stray start at cycle 5.
    cfg_k = 8'd3; cfg_n = 16'd2; cfg_base = 10'd0; cfg_stride = 10'd1;
    out_ready = 1'b1; convout = 8'(-20); start = 1'b1;
    ai = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (c == 5) begin
        start = 1'b1; cfg_k = 8'd9; cfg_n = 16'd7; cfg_base = 10'd500; cfg_stride = 10'd50;
      end
      if (c == 6) start = 1'b0;
      exp_issue = (c >= 1 && c <= 3) || (c >= 8 && c <= 10);
      exp_clken = (c >= 2 && c <= 4) || (c >= 9 && c <= 11);
      exp_sload = (c == 2) || (c == 9);
      exp_valid = (c == 7) || (c == 14);
      exp_done  = (c == 15);
      exp_busy  = (c <= 15);
      check($sformatf("t2_mem_rd_c%0d", c), 64'(mem_rd), 64'(exp_issue));
      check($sformatf("t2_clken_c%0d", c), 64'(mac_clken), 64'(exp_clken));
      check($sformatf("t2_sload_c%0d", c), 64'(mac_sload), 64'(exp_sload));
      check($sformatf("t2_valid_c%0d", c), 64'(out_valid), 64'(exp_valid));
      check($sformatf("t2_done_c%0d", c), 64'(done), 64'(exp_done));
      check($sformatf("t2_busy_c%0d", c), 64'(busy), 64'(exp_busy));
      check($sformatf("t2_en_sat_c%0d", c), 64'({mac_en_sat, mac_en_mult_r}), 64'({exp_busy, exp_busy}));
      if (mem_rd && ai < 6) begin
        check($sformatf("t2_sig_addr_%0d", ai), 64'(sig_addr), 64'(exp_sa2[ai]));
        check($sformatf("t2_w_addr_%0d", ai), 64'(w_addr), 64'(exp_wa2[ai]));
        ai++;
      end
      if (c == 7) begin
        check("t2_out_data_w0", 64'(out_data), 64'(8'shF2));
        check("t2_out_idx_w0", 64'(out_idx), 64'd0);
      end
      if (c == 14) begin
        check("t2_out_data_w1", 64'(out_data), 64'(8'shF9));
        check("t2_out_idx_w1", 64'(out_idx), 64'd1);
      end
      convout = 8'(c - 20);
    end
    check("t2_read_count", 64'(ai), 64'd6);

    // K=4, N=1, ready held low for five EMIT cycles.
    cfg_k = 8'd4; cfg_n = 16'd1; cfg_base = 10'd100; cfg_stride = 10'd5;
    out_ready = 1'b0; convout = 8'sh5A; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) start = 1'b0;
    end
    check("t3_valid_c7", 64'(out_valid), 64'd0);
    step();
    check("t3_valid_c8", 64'(out_valid), 64'd1);
    check("t3_data_c8", 64'(out_data), 64'(8'sh5A));
    check("t3_idx_c8", 64'(out_idx), 64'd0);
    convout = 8'sh11;
    for (int c = 9; c <= 13; c++) begin
      step();
      check($sformatf("t3_valid_c%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("t3_data_c%0d", c), 64'(out_data), 64'(8'sh5A));
      if (c == 13) out_ready = 1'b1;
    end
    step();
    check("t3_valid_after_hs", 64'(out_valid), 64'd0);
    check("t3_done", 64'(done), 64'd1);
    step();
    check("t3_busy_end", 64'({busy, done}), 64'd0);

    // cfg_k = 0: immediate done, no reads, no strobes, no results.
    cfg_k = 8'd0; cfg_n = 16'd5; cfg_base = 10'd3; cfg_stride = 10'd1; start = 1'b1;
    step();
    start = 1'b0;
    check("t4_done_c1", 64'(done), 64'd1);
    seen_any = mem_rd | mac_clken | out_valid;
    for (int c = 2; c <= 5; c++) begin
      step();
      if (c == 2) check("t4_idle_c2", 64'({busy, done}), 64'd0);
      seen_any = seen_any | mem_rd | mac_clken | out_valid;
    end
    check("t4_no_activity", 64'(seen_any), 64'd0);

    // Address wrap: base 1020, stride 3, K=4, N=2.
    cfg_k = 8'd4; cfg_n = 16'd2; cfg_base = 10'd1020; cfg_stride = 10'd3;
    out_ready = 1'b1; start = 1'b1; got_done = 1'b0;
    addr_q.delete();
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 0) start = 1'b0;
      if (mem_rd) addr_q.push_back(sig_addr);
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("t5_done_seen", 64'(got_done), 64'd1);
    check("t5_addr_count", 64'(addr_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < addr_q.size()) check($sformatf("t5_addr_%0d", i), 64'(addr_q[i]), 64'(exp_sa5[i]));
    end
    step();

    // Reset mid-ISSUE with K=9, then a normal run.
    cfg_k = 8'd9; cfg_n = 16'd3; cfg_base = 10'd40; cfg_stride = 10'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("t6_mid_issue_addr", 64'({mem_rd, sig_addr}), 64'({1'b1, 10'd43}));
    check("t6_mid_issue_clken", 64'(mac_clken), 64'd1);
    reset = 1'b1;
    step();
    check("t6_reset_all_outputs", all_outs(), 64'd0);
    reset = 1'b0;
    seen_any = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      seen_any = seen_any | busy | done | mem_rd;
    end
    check("t6_stays_idle", 64'(seen_any), 64'd0);
    cfg_k = 8'd2; cfg_n = 16'd1; cfg_base = 10'd7; cfg_stride = 10'd9;
    convout = 8'sh33; start = 1'b1;
    step();
    start = 1'b0;
    check("t6_restart_addr0", 64'({mem_rd, sig_addr}), 64'({1'b1, 10'd7}));
    step();
    check("t6_restart_addr1", 64'({mem_rd, sig_addr}), 64'({1'b1, 10'd8}));
    step(); step(); step(); step();
    check("t6_restart_valid", 64'({out_valid, out_idx}), 64'({1'b1, 16'd0}));
    check("t6_restart_data", 64'(out_data), 64'(8'sh33));
    step();
    check("t6_restart_done", 64'(done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
